// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default datapath width and a legality helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // True for the four opcodes the ALU core implements; everything else is flagged illegal.
    function automatic logic alu_op_legal(input logic [2:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Request/response bundle for the ALU issue stage: valid/ready request channel and valid/ready result channel.
// Latency: n/a (wires only).
// Backpressure: in_ready from the stage, out_ready from the consumer.
// Ports: slave = stage view (consumes requests, produces results); master = requester/consumer view.
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_zero;
    logic             out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_z, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_z, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: AND/OR/ADD/SUB on two operands, with zero and illegal-opcode flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is captured.
// Ports: a, b operands; op opcode; z result (0 for illegal ops); zero = (z == 0); illegal = unknown opcode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             illegal
);

    always_comb begin
        z       = '0;
        illegal = 1'b0;
        case (op)
            ALU_AND: z = a & b;
            ALU_OR:  z = a | b;
            ALU_ADD: z = a + b;
            // Two's-complement subtract, wraps modulo 2^WIDTH.
            ALU_SUB: z = a + ~b + WIDTH'(1);
            default: illegal = 1'b1;
        endcase
        zero = (z == '0);
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage: captures ALU results into a 2-entry FIFO and counts retired results (saturating).
// Latency: result visible on out_* one cycle after accept into an empty buffer; 1 result/cycle sustained.
// Backpressure: in_ready = buffer not full, from registered occupancy only (no out_ready -> in_ready path).
// Ports: clk, rst_n (async active-low); bus (slave modport: in_* request, out_* result);
//        clear_count (sync clear, wins over a retire); done_count (saturating retire count).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_stage_if.slave bus,
    input  logic             clear_count,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] core_z;
    logic             core_zero;
    logic             core_illegal;

    // Payload storage, one slot per buffer entry.
    logic [WIDTH-1:0] z_q [2];
    logic [WIDTH-1:0] z_d [2];
    logic [1:0]       zero_q, zero_d;
    logic [1:0]       ill_q, ill_d;

    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (bus.in_a),
        .b       (bus.in_b),
        .op      (bus.in_op),
        .z       (core_z),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    assign bus.in_ready    = (occ_q != 2'd2);
    assign bus.out_valid   = (occ_q != 2'd0);
    // Storage is reset, so the head reads 0 while empty after reset.
    assign bus.out_z       = z_q[head_q];
    assign bus.out_zero    = zero_q[head_q];
    assign bus.out_illegal = ill_q[head_q];
    assign done_count      = cnt_q;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        z_d    = z_q;
        zero_d = zero_q;
        ill_d  = ill_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;

        if (in_fire) begin
            z_d[tail_q]    = core_z;
            zero_d[tail_q] = core_zero;
            ill_d[tail_q]  = core_illegal;
            tail_d         = ~tail_q;
        end
        if (out_fire) begin
            head_d = ~head_q;
        end

        // Simultaneous accept and retire leaves occupancy unchanged.
        occ_d = occ_q + {1'b0, in_fire} - {1'b0, out_fire};

        if (clear_count) begin
            cnt_d = '0;
        end else if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q[0] <= '0;
            z_q[1] <= '0;
            zero_q <= '0;
            ill_q  <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
            cnt_q  <= '0;
        end else begin
            z_q    <= z_d;
            zero_q <= zero_d;
            ill_q  <= ill_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases, back-pressure, random streaming, reset and counter edges.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
`timescale 1ns/1ps
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        clr2  = 1'b0;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(32)) bus ();
    alu_issue_stage_if #(.WIDTH(32)) bus2 ();

    alu_issue_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .clear_count (clr),
        .done_count  (cnt)
    );

    alu_issue_stage #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2),
        .clear_count (clr2),
        .done_count  (cnt2)
    );

    typedef struct {
        logic [31:0] z;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          n_ret = 0;
    int          mark  = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    logic [15:0] exp_cnt = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference behaviour straight from the opcode table.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t e;
        e.ill = 1'b0;
        case (op)
            3'b000:  e.z = a & b;
            3'b001:  e.z = a | b;
            3'b010:  e.z = a + b;
            3'b110:  e.z = a - b;
            default: begin e.z = 32'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.z == 32'd0);
        return e;
    endfunction

    // Monitor: checks the head against the scoreboard every cycle, pops on retire,
    // tracks the expected counter, and records accepted requests.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 16'd0;
        end else begin
            chk("done_count", 32'(cnt), 32'(exp_cnt));
            chk("out_valid_vs_sb", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("head_z", bus.out_z, exp_q[0].z);
                chk("head_zero", 32'(bus.out_zero), 32'(exp_q[0].zero));
                chk("head_illegal", 32'(bus.out_illegal), 32'(exp_q[0].ill));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    if (n_ret == mark) first_cyc = cyc;
                    last_cyc = cyc;
                    n_ret++;
                end
            end
            if (clr)
                exp_cnt = 16'd0;
            else if (bus.out_valid && bus.out_ready && exp_cnt != 16'hFFFF)
                exp_cnt = exp_cnt + 16'd1;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
        end
    end

    // Present a request and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_op      = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_a      = 32'd1;
        bus2.in_b      = 32'd2;
        bus2.in_op     = ALU_ADD;
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_z", bus.out_z, 32'd0);
        chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // Single ADD, visible right after the accepting edge.
        send(32'd5, 32'd7, ALU_ADD);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_z", bus.out_z, 32'd12);
        chk("add_zero", 32'(bus.out_zero), 32'd0);
        @(posedge clk);
        #1;
        chk("add_count", 32'(cnt), 32'd1);

        send(32'd3, 32'd3, ALU_SUB);
        chk("sub_eq_z", bus.out_z, 32'd0);
        chk("sub_eq_zero", 32'(bus.out_zero), 32'd1);
        send(32'd0, 32'd1, ALU_SUB);
        chk("sub_wrap_z", bus.out_z, 32'hFFFF_FFFF);
        send(32'hFFFF_FFFF, 32'd1, ALU_ADD);
        chk("add_wrap_z", bus.out_z, 32'd0);
        chk("add_wrap_zero", 32'(bus.out_zero), 32'd1);
        send(32'd9, 32'd4, 3'b011);
        chk("ill_z", bus.out_z, 32'd0);
        chk("ill_zero", 32'(bus.out_zero), 32'd1);
        chk("ill_flag", 32'(bus.out_illegal), 32'd1);
        drain();

        // Back-pressure: two accepts fill the buffer, third waits.
        bus.out_ready = 1'b0;
        send(32'hF0F0, 32'hFF00, ALU_AND);
        send(32'h0F, 32'hF0, ALU_OR);
        @(negedge clk);
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_a     = 32'd1;
        bus.in_b     = 32'd1;
        bus.in_op    = ALU_ADD;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head_held", bus.out_z, 32'h0000_F000);
        bus.out_ready = 1'b1;
        send(32'd1, 32'd1, ALU_ADD);
        drain();

        // Clear coincident with a retire: clear wins.
        send(32'd2, 32'd2, ALU_ADD);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clear_wins", 32'(cnt), 32'd0);
        drain();

        // Random streaming at full rate.
        mark = n_ret;
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 3'($urandom_range(0, 7)));
        drain();
        chk("stream_retired", 32'(n_ret - mark), 32'd100);
        chk("stream_span", 32'(last_cyc - first_cyc), 32'd99);
        chk("stream_count", 32'(cnt), 32'd100);

        // Reset while the buffer is full.
        bus.out_ready = 1'b0;
        send(32'd10, 32'd20, ALU_OR);
        send(32'd30, 32'd40, ALU_ADD);
        @(negedge clk);
        chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_z", bus.out_z, 32'd0);
        chk("mid_rst_count", 32'(cnt), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_after_rst", 32'(bus.out_valid), 32'd0);

        // Narrow counter saturates at 3 after 5 retires.
        bus2.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_count", 32'(cnt2), 32'd3);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered issue/retire stage wrapped around the combinational ALU in the execute path. Accepts operand/opcode requests over a valid/ready handshake, evaluates them through the ALU core, and holds results in a 2-entry output buffer so downstream back-pressure never drops or duplicates a result. It also keeps a saturating count of retired operations.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of retired-operation counter
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept a request this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB; all others illegal
- out_valid  out  1  result available at buffer head
- out_ready  in  1  consumer takes head this cycle
- out_z  out  WIDTH  result at head
- out_zero  out  1  head result equals 0
- out_illegal  out  1  head came from an illegal opcode
- clear_count  in  1  synchronous clear of done_count
- done_count  out  CNT_W  number of results retired, saturating

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- On input fire, the ALU core result {z, zero, illegal} is written to the buffer tail at the clock edge.
- Buffer: 2 entries, FIFO order, occupancy 0/1/2.
- in_ready = (occupancy < 2). It is a function of registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (occupancy > 0). out_z, out_zero and out_illegal show the head entry and are held stable while out_valid && !out_ready.
- Simultaneous input and output fire at occupancy 1: the head retires, the new entry becomes head, and occupancy stays 1. At occupancy 2, input cannot fire.
- Arithmetic: all results are modulo 2^WIDTH. SUB = a + ~b + 1. No carry or overflow outputs.
- Illegal opcode: z = 0, zero = 1, illegal = 1. The entry is buffered and retired like any other.
- done_count increments by 1 on each output fire and saturates at 2^CNT_W−1. If clear_count and an output fire occur in the same cycle, clear wins and the count becomes 0.
- Reset (asynchronous, any time, including mid-transfer): occupancy 0, head/tail pointers 0, done_count 0, out_valid 0, in_ready 1, out_z 0, out_zero 0, out_illegal 0. Buffered entries are discarded.

## Timing
- Latency: a request accepted at edge N is visible on out_* after edge N when the buffer was empty. With one entry ahead, it is visible one retire later.
- Throughput: 1 result/cycle sustained while out_ready = 1.
- After reset deassertion, in_ready = 1 in the first cycle.
- A handshake is sampled only at the rising edge of clk; inputs need to be stable only around that edge.
- Payload buffer storage may be left unreset, provided out_z/out_zero/out_illegal read 0 while out_valid = 0 after reset.

## Structure
- Shared package `alu_pkg`: opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, and the WIDTH default.
- Sub-module `alu_core`: purely combinational, (a, b, op) -> (z, zero, illegal). It is reused unchanged by the single-cycle datapath.
- Top level holds the 2-entry buffer (storage array, 1-bit head/tail pointers, 2-bit occupancy) and the counter.

## Test plan
- Reset, then single ADD with a=5, b=7 and out_ready=1 -> out_valid 1 cycle after accept, out_z=12, out_zero=0, done_count=1.
- SUB with a=3, b=3 -> out_z=0, out_zero=1. SUB with a=0, b=1 -> out_z=32'hFFFF_FFFF. ADD with a=32'hFFFF_FFFF, b=1 -> out_z=0, out_zero=1.
- Back-pressure: hold out_ready=0 and offer 3 requests (AND 0xF0F0/0xFF00, OR 0x0F/0xF0, ADD 1/1) -> in_ready drops after 2 accepts. Then raise out_ready -> results retire in order as 0xF000, 0xFF, 2, with no loss or duplication.
- Streaming: 100 random requests with in_valid=1 and out_ready=1 -> one retire per cycle after the first, every result matches a reference model, done_count=100.
- Illegal op 3'b011 with a=9, b=4 -> out_z=0, out_zero=1, out_illegal=1, and the entry retires normally.
- Edge cases: assert rst_n low while occupancy=2 -> out_valid=0 and in_ready=1 immediately, and no stale result appears afterwards. Assert clear_count in the same cycle as a retire -> done_count=0. With CNT_W=2, 5 retires -> done_count=3.
